uart_tx_arbiter: RTL and testbench

Shares the single UART transmitter among `NUM_REQ` byte requesters with round-robin fairness. It sits between the requesting blocks and the `tx` instance in `uart_top`, and drives `tx_start`/`tx_data` while consuming `tx_done`. Each granted byte is optionally preceded by a header byte that identifies the requester. A watchdog recovers the arbiter if the transmitter never reports completion.

---
 rtl/uart_ctrl_pkg.sv | 24 ++
 rtl/rr_arbiter.sv | 30 +++
 rtl/uart_tx_arbiter.sv | 117 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_ctrl_pkg                                                          |
// | State encoding and header tag shared by the UART transmit arbiter.    |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
package uart_ctrl_pkg;

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_HDR_WAIT   = 2'd1;
  localparam logic [1:0] ST_DATA_START = 2'd2;
  localparam logic [1:0] ST_DATA_WAIT  = 2'd3;

  localparam logic [3:0] HDR_TAG = 4'hA;

  typedef enum logic [1:0] {
    IDLE       = ST_IDLE,
    HDR_WAIT   = ST_HDR_WAIT,
    DATA_START = ST_DATA_START,
    DATA_WAIT  = ST_DATA_WAIT
  } state_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_arbiter                                                             |
// | Combinational round-robin pick: first set request at or after ptr.    |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          gnt_valid,
  output logic [IW-1:0] gnt_idx
);

  // Scan offsets from farthest to nearest so the nearest hit is written last.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        gnt_valid = 1'b1;
        gnt_idx   = IW'((int'(ptr) + k) % N);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_tx_arbiter                                                        |
// | Round-robin sharing of one UART transmitter, optional ID header,      |
// | watchdog abort on a missing tx_done.                                  |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
module uart_tx_arbiter
  import uart_ctrl_pkg::*;
#(
  parameter  int NUM_REQ        = 4,
  parameter  int ID_HEADER      = 1,
  parameter  int TIMEOUT_CYCLES = 200000,
  localparam int C_IDW          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int C_WDW          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]     req_ack,
  output logic                   tx_start,
  output logic [7:0]             tx_data,
  input  logic                   tx_done,
  output logic                   busy,
  output logic [C_IDW-1:0]       grant_id,
  output logic                   timeout_err
);

  state_t             r_state;
  logic [C_IDW-1:0]   r_rr_ptr;
  logic [7:0]         r_payload;
  logic [C_WDW-1:0]   r_wd;

  logic               w_gnt_valid;
  logic [C_IDW-1:0]   w_gnt_idx;
  logic [7:0]         w_req_byte;
  logic               w_wd_expired;

  rr_arbiter #(.N(NUM_REQ)) u_rr_arbiter (
    .req       (req_valid),
    .ptr       (r_rr_ptr),
    .gnt_valid (w_gnt_valid),
    .gnt_idx   (w_gnt_idx)
  );

  assign w_req_byte   = req_data[8*int'(w_gnt_idx) +: 8];
  // Expiry is judged on the edge that would bring the count to TIMEOUT_CYCLES.
  assign w_wd_expired = (r_wd == C_WDW'(TIMEOUT_CYCLES - 1));
  assign busy         = (r_state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_rr_ptr    <= '0;
      r_payload   <= 8'h00;
      r_wd        <= '0;
      req_ack     <= '0;
      tx_start    <= 1'b0;
      tx_data     <= 8'h00;
      grant_id    <= '0;
      timeout_err <= 1'b0;
    end else begin
      req_ack     <= '0;
      tx_start    <= 1'b0;
      timeout_err <= 1'b0;
      if ((r_state == HDR_WAIT || r_state == DATA_WAIT) && r_wd != C_WDW'(TIMEOUT_CYCLES))
        r_wd <= r_wd + C_WDW'(1);
      case (r_state)
        IDLE: begin
          if (w_gnt_valid) begin
            r_payload <= w_req_byte;
            grant_id  <= w_gnt_idx;
            req_ack   <= NUM_REQ'(1) << w_gnt_idx;
            r_rr_ptr  <= (w_gnt_idx == C_IDW'(NUM_REQ - 1)) ? '0 : w_gnt_idx + C_IDW'(1);
            tx_start  <= 1'b1;
            r_wd      <= '0;
            if (ID_HEADER != 0) begin
              tx_data <= {HDR_TAG, 4'(w_gnt_idx)};
              r_state <= HDR_WAIT;
            end else begin
              tx_data <= w_req_byte;
              r_state <= DATA_WAIT;
            end
          end
        end
        HDR_WAIT: begin
          if (tx_done) begin
            r_state <= DATA_START;
          end else if (w_wd_expired) begin
            timeout_err <= 1'b1;
            r_payload   <= 8'h00;
            r_state     <= IDLE;
          end
        end
        DATA_START: begin
          tx_start <= 1'b1;
          tx_data  <= r_payload;
          r_wd     <= '0;
          r_state  <= DATA_WAIT;
        end
        DATA_WAIT: begin
          if (tx_done) begin
            r_state <= IDLE;
          end else if (w_wd_expired) begin
            timeout_err <= 1'b1;
            r_payload   <= 8'h00;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_uart_tx_arbiter                                                     |
// | Directed scenarios for the UART transmit arbiter, header and no-header|
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_ack;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_done = 1'b0;
  logic        busy;
  logic [1:0]  grant_id;
  logic        timeout_err;

  logic [3:0]  nh_req_valid = '0;
  logic [31:0] nh_req_data = '0;
  logic [3:0]  nh_req_ack;
  logic        nh_tx_start;
  logic [7:0]  nh_tx_data;
  logic        nh_tx_done = 1'b0;
  logic        nh_busy;
  logic [1:0]  nh_grant_id;
  logic        nh_timeout_err;

  int n_vec = 0;
  int n_err = 0;
  logic prev_start = 1'b0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(4), .ID_HEADER(1), .TIMEOUT_CYCLES(50)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ack(req_ack), .tx_start(tx_start), .tx_data(tx_data), .tx_done(tx_done),
    .busy(busy), .grant_id(grant_id), .timeout_err(timeout_err)
  );

  uart_tx_arbiter #(.NUM_REQ(4), .ID_HEADER(0), .TIMEOUT_CYCLES(50)) dut_nh (
    .clk(clk), .reset(reset), .req_valid(nh_req_valid), .req_data(nh_req_data),
    .req_ack(nh_req_ack), .tx_start(nh_tx_start), .tx_data(nh_tx_data), .tx_done(nh_tx_done),
    .busy(nh_busy), .grant_id(nh_grant_id), .timeout_err(nh_timeout_err)
  );

  // tx_start must never repeat on adjacent cycles; at most one ack bit at a time.
  always @(negedge clk) begin
    if (!reset) begin
      if (tx_start) begin
        n_vec++;
        if (prev_start) begin
          n_err++;
          $display("FAIL start_duty got=two consecutive tx_start exp=isolated pulse");
        end
      end
      if (req_ack != 4'b0000) begin
        n_vec++;
        if ($countones(req_ack) > 1) begin
          n_err++;
          $display("FAIL ack_onehot got=%b exp=one bit", req_ack);
        end
      end
    end
    prev_start <= tx_start;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    reset = 1'b1; tx_done = 1'b0; nh_tx_done = 1'b0;
    req_valid = '0; nh_req_valid = '0;
    repeat (2) tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic pulse_done();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  task automatic wait_start(input int max_cyc, output int cyc);
    cyc = 0;
    while (!tx_start && cyc < max_cyc) begin
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_vec++; if (tx_start !== 1'b0) begin n_err++; $display("FAIL reset_tx_start got=%b exp=0", tx_start); end
    n_vec++; if (tx_data !== 8'h00) begin n_err++; $display("FAIL reset_tx_data got=%h exp=00", tx_data); end
    n_vec++; if (req_ack !== 4'b0000) begin n_err++; $display("FAIL reset_req_ack got=%b exp=0000", req_ack); end
    n_vec++; if (grant_id !== 2'd0) begin n_err++; $display("FAIL reset_grant_id got=%0d exp=0", grant_id); end
    n_vec++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL reset_timeout_err got=%b exp=0", timeout_err); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single();
    apply_reset();
    req_data = '0; req_data[23:16] = 8'h5A; req_valid = 4'b0100;
    tick();
    n_vec++; if (req_ack !== 4'b0100) begin n_err++; $display("FAIL single_ack got=%b exp=0100", req_ack); end
    n_vec++; if (tx_start !== 1'b1) begin n_err++; $display("FAIL single_hdr_start got=%b exp=1", tx_start); end
    n_vec++; if (tx_data !== 8'hA2) begin n_err++; $display("FAIL single_hdr_data got=%h exp=a2", tx_data); end
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy got=%b exp=1", busy); end
    n_vec++; if (grant_id !== 2'd2) begin n_err++; $display("FAIL single_grant got=%0d exp=2", grant_id); end
    req_valid = '0;
    tick();
    n_vec++; if (req_ack !== 4'b0000) begin n_err++; $display("FAIL single_ack_pulse got=%b exp=0000", req_ack); end
    n_vec++; if (tx_data !== 8'hA2) begin n_err++; $display("FAIL single_hdr_hold got=%h exp=a2", tx_data); end
    repeat (3) tick();
    pulse_done();
    n_vec++; if (tx_start !== 1'b0) begin n_err++; $display("FAIL single_data_start_gap got=%b exp=0", tx_start); end
    tick();
    n_vec++; if (tx_start !== 1'b1) begin n_err++; $display("FAIL single_data_start got=%b exp=1", tx_start); end
    n_vec++; if (tx_data !== 8'h5A) begin n_err++; $display("FAIL single_data got=%h exp=5a", tx_data); end
    tick(); tick();
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy_wait got=%b exp=1", busy); end
    pulse_done();
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_busy_fall got=%b exp=0", busy); end
    n_vec++; if (grant_id !== 2'd2) begin n_err++; $display("FAIL single_grant_last got=%0d exp=2", grant_id); end
  endtask

  task automatic test_all_requesters();
    int cyc;
    logic [1:0] id;
    logic [3:0] exp_ack;
    apply_reset();
    req_data = {8'h13, 8'h12, 8'h11, 8'h10};
    req_valid = 4'hF;
    for (int g = 0; g < 5; g++) begin
      id = 2'(g % 4);
      exp_ack = 4'b0001 << id;
      wait_start(10, cyc);
      n_vec++; if (tx_start !== 1'b1) begin n_err++; $display("FAIL all_start_timeout got=%b exp=1 grant=%0d", tx_start, g); end
      if (g > 0) begin
        n_vec++; if (cyc != 1) begin n_err++; $display("FAIL all_b2b_latency got=%0d exp=1", cyc); end
      end
      n_vec++; if (grant_id !== id) begin n_err++; $display("FAIL all_grant got=%0d exp=%0d", grant_id, id); end
      n_vec++; if (req_ack !== exp_ack) begin n_err++; $display("FAIL all_ack got=%b exp=%b", req_ack, exp_ack); end
      n_vec++; if (tx_data !== {4'hA, 2'b00, id}) begin n_err++; $display("FAIL all_hdr got=%h exp=%h", tx_data, {4'hA, 2'b00, id}); end
      tick();
      pulse_done();
      tick();
      n_vec++; if (tx_start !== 1'b1) begin n_err++; $display("FAIL all_data_start got=%b exp=1", tx_start); end
      n_vec++; if (tx_data !== 8'h10 + 8'(id)) begin n_err++; $display("FAIL all_data got=%h exp=%h", tx_data, 8'h10 + 8'(id)); end
      pulse_done();
      if (g == 4) req_valid = '0;
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL all_idle got=%b exp=0", busy); end
    end
    tick();
  endtask

  task automatic test_late_arrival();
    int cyc;
    apply_reset();
    req_data = '0; req_data[31:24] = 8'h77; req_valid = 4'b1000;
    wait_start(5, cyc);
    n_vec++; if (grant_id !== 2'd3) begin n_err++; $display("FAIL late_first_grant got=%0d exp=3", grant_id); end
    n_vec++; if (tx_data !== 8'hA3) begin n_err++; $display("FAIL late_first_hdr got=%h exp=a3", tx_data); end
    req_valid = 4'b0010; req_data[15:8] = 8'h31;
    tick();
    n_vec++; if (req_ack !== 4'b0000) begin n_err++; $display("FAIL late_ack_hdr got=%b exp=0000", req_ack); end
    tick();
    pulse_done();
    tick();
    n_vec++; if (tx_data !== 8'h77) begin n_err++; $display("FAIL late_first_data got=%h exp=77", tx_data); end
    n_vec++; if (req_ack !== 4'b0000) begin n_err++; $display("FAIL late_ack_data got=%b exp=0000", req_ack); end
    tick();
    pulse_done();
    n_vec++; if (req_ack !== 4'b0000) begin n_err++; $display("FAIL late_ack_idle got=%b exp=0000", req_ack); end
    tick();
    n_vec++; if (req_ack !== 4'b0010) begin n_err++; $display("FAIL late_ack got=%b exp=0010", req_ack); end
    n_vec++; if (grant_id !== 2'd1) begin n_err++; $display("FAIL late_grant got=%0d exp=1", grant_id); end
    n_vec++; if (tx_data !== 8'hA1) begin n_err++; $display("FAIL late_hdr got=%h exp=a1", tx_data); end
    req_valid = '0;
    tick(); pulse_done(); tick(); pulse_done();
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL late_end_idle got=%b exp=0", busy); end
  endtask

  task automatic test_watchdog();
    int cyc;
    int n;
    apply_reset();
    req_data = '0; req_data[7:0] = 8'hEE; req_valid = 4'b0001;
    wait_start(5, cyc);
    req_valid = '0;
    n = 0;
    while (!timeout_err && n < 100) begin
      tick();
      n++;
    end
    n_vec++; if (n != 50) begin n_err++; $display("FAIL wd_latency got=%0d exp=50", n); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL wd_idle got=%b exp=0", busy); end
    tick();
    n_vec++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL wd_pulse got=%b exp=0", timeout_err); end
    req_data[15:8] = 8'h42; req_valid = 4'b0010;
    wait_start(5, cyc);
    n_vec++; if (grant_id !== 2'd1) begin n_err++; $display("FAIL wd_next_grant got=%0d exp=1", grant_id); end
    n_vec++; if (tx_data !== 8'hA1) begin n_err++; $display("FAIL wd_next_hdr got=%h exp=a1", tx_data); end
    req_valid = '0;
    repeat (49) tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    n_vec++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL wd_terminal_done got=%b exp=0", timeout_err); end
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL wd_terminal_busy got=%b exp=1", busy); end
    tick();
    n_vec++; if (tx_start !== 1'b1) begin n_err++; $display("FAIL wd_next_start got=%b exp=1", tx_start); end
    n_vec++; if (tx_data !== 8'h42) begin n_err++; $display("FAIL wd_next_data got=%h exp=42", tx_data); end
    tick();
    pulse_done();
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL wd_next_idle got=%b exp=0", busy); end
  endtask

  task automatic test_mid_reset();
    int cyc;
    apply_reset();
    req_data = '0; req_data[23:16] = 8'h99; req_valid = 4'b0100;
    wait_start(5, cyc);
    req_valid = '0;
    tick();
    pulse_done();
    tick();
    n_vec++; if (tx_start !== 1'b1) begin n_err++; $display("FAIL mrst_pre_start got=%b exp=1", tx_start); end
    req_data = {8'h13, 8'h12, 8'h11, 8'h10}; req_valid = 4'hF;
    #1 reset = 1'b1;
    #1;
    n_vec++; if (tx_start !== 1'b0) begin n_err++; $display("FAIL mrst_tx_start got=%b exp=0", tx_start); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL mrst_busy got=%b exp=0", busy); end
    n_vec++; if (tx_data !== 8'h00) begin n_err++; $display("FAIL mrst_tx_data got=%h exp=00", tx_data); end
    n_vec++; if (grant_id !== 2'd0) begin n_err++; $display("FAIL mrst_grant got=%0d exp=0", grant_id); end
    tick();
    reset = 1'b0;
    wait_start(5, cyc);
    n_vec++; if (grant_id !== 2'd0) begin n_err++; $display("FAIL mrst_first_grant got=%0d exp=0", grant_id); end
    n_vec++; if (req_ack !== 4'b0001) begin n_err++; $display("FAIL mrst_first_ack got=%b exp=0001", req_ack); end
    n_vec++; if (tx_data !== 8'hA0) begin n_err++; $display("FAIL mrst_first_hdr got=%h exp=a0", tx_data); end
    req_valid = '0;
    tick(); pulse_done(); tick(); pulse_done();
  endtask

  task automatic test_no_header();
    int starts;
    apply_reset();
    nh_req_data = '0; nh_req_data[7:0] = 8'hC3; nh_req_valid = 4'b0001;
    tick();
    n_vec++; if (nh_tx_start !== 1'b1) begin n_err++; $display("FAIL nh_start got=%b exp=1", nh_tx_start); end
    n_vec++; if (nh_tx_data !== 8'hC3) begin n_err++; $display("FAIL nh_data got=%h exp=c3", nh_tx_data); end
    n_vec++; if (nh_req_ack !== 4'b0001) begin n_err++; $display("FAIL nh_ack got=%b exp=0001", nh_req_ack); end
    n_vec++; if (nh_busy !== 1'b1) begin n_err++; $display("FAIL nh_busy got=%b exp=1", nh_busy); end
    nh_req_valid = '0;
    starts = (nh_tx_start === 1'b1) ? 1 : 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (nh_tx_start) starts++;
    end
    nh_tx_done = 1'b1;
    tick();
    nh_tx_done = 1'b0;
    if (nh_tx_start) starts++;
    n_vec++; if (nh_busy !== 1'b0) begin n_err++; $display("FAIL nh_idle got=%b exp=0", nh_busy); end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (nh_tx_start) starts++;
    end
    n_vec++; if (starts != 1) begin n_err++; $display("FAIL nh_start_count got=%0d exp=1", starts); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_requesters();
    test_late_arrival();
    test_watchdog();
    test_mid_reset();
    test_no_header();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=still running exp=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
`default_nettype wire
